// File: rtl/wavelet_dma_streamer_if.sv
// Byte-wide CPU-bus port of the wavelet accelerator, seen from its bus master (master)
// and from the accelerator side (slave).
interface wavelet_dma_streamer_if #(
    parameter int unsigned ADDR_BUS_WIDTH = 32
);
    logic [ADDR_BUS_WIDTH-1:0] bus_addr;
    logic [7:0]                bus_data_out;
    logic                      bus_write_en;
    logic                      bus_read_en;
    logic [7:0]                bus_data_in;
    logic                      bus_data_ready;

    modport master (
        output bus_addr, bus_data_out, bus_write_en, bus_read_en,
        input  bus_data_in, bus_data_ready
    );

    modport slave (
        input  bus_addr, bus_data_out, bus_write_en, bus_read_en,
        output bus_data_in, bus_data_ready
    );
endinterface

// File: rtl/wavelet_dma_streamer.sv
// Autonomous bus master: configures the wavelet accelerator, streams samples in from a
// source SRAM byte by byte, then polls status and drains results into a destination SRAM.
module wavelet_dma_streamer #(
    parameter int unsigned                  ADDR_BUS_WIDTH    = 32,
    parameter logic [ADDR_BUS_WIDTH-1:0]    BASE_ADDRESS      = 32'h1A100000,
    parameter logic [1:0]                   CONFIG_REG_OFFSET = 2'b00,
    parameter logic [1:0]                   INPUT_REG_OFFSET  = 2'b01,
    parameter logic [1:0]                   OUTPUT_REG_OFFSET = 2'b10,
    parameter int unsigned                  SAMPLE_WIDTH      = 32,
    parameter int unsigned                  MEM_ADDR_WIDTH    = 12,
    parameter int unsigned                  STATUS_BIT        = 2,
    parameter int unsigned                  TIMEOUT_CYCLES    = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] in_count,
    input  logic [MEM_ADDR_WIDTH-1:0] out_count,
    input  logic [15:0]               cfg_init_word,
    input  logic [15:0]               cfg_go_word,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic                      src_rd_en,
    output logic [MEM_ADDR_WIDTH-1:0] src_addr,
    input  logic [SAMPLE_WIDTH-1:0]   src_data,
    output logic                      dst_wr_en,
    output logic [MEM_ADDR_WIDTH-1:0] dst_addr,
    output logic [SAMPLE_WIDTH-1:0]   dst_data,
    wavelet_dma_streamer_if.master    bus
);
    localparam int unsigned TW          = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  STATUS_BYTE = 2'(STATUS_BIT / 8);
    localparam int unsigned STATUS_POS  = STATUS_BIT % 8;

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_INIT, S_FETCH, S_FETCH_WAIT, S_IN_WR, S_CFG_GO,
        S_POLL, S_POLL_GAP, S_OUT_RD, S_STORE, S_DONE
    } state_e;

    state_e                    state_q;
    logic [MEM_ADDR_WIDTH-1:0] in_cnt_q, out_cnt_q, in_idx_q, out_idx_q;
    logic [15:0]               init_q, go_q;
    logic [1:0]                byte_q;
    logic [SAMPLE_WIDTH-1:0]   sample_q;
    logic [SAMPLE_WIDTH-9:0]   res_q;
    logic [TW-1:0]             timer_q;
    logic                      status_q, busy_q, done_q, error_q;
    logic                      src_rd_en_q, dst_wr_en_q;
    logic [MEM_ADDR_WIDTH-1:0] src_addr_q, dst_addr_q;
    logic [SAMPLE_WIDTH-1:0]   dst_data_q;
    logic [ADDR_BUS_WIDTH-1:0] bus_addr_q;
    logic [7:0]                bus_data_out_q;
    logic                      bus_write_en_q, bus_read_en_q;

    logic [1:0]                byte_nxt;
    logic [MEM_ADDR_WIDTH:0]   in_idx_nxt, out_idx_nxt;

    assign byte_nxt    = byte_q + 2'd1;
    assign in_idx_nxt  = {1'b0, in_idx_q} + (MEM_ADDR_WIDTH + 1)'(1);
    assign out_idx_nxt = {1'b0, out_idx_q} + (MEM_ADDR_WIDTH + 1)'(1);

    function automatic logic [ADDR_BUS_WIDTH-1:0] reg_addr(input logic [1:0] off,
                                                           input logic [1:0] idx);
        return BASE_ADDRESS + ADDR_BUS_WIDTH'({off, 2'b00}) + ADDR_BUS_WIDTH'(idx);
    endfunction

    // Every strobe is registered and defaults low each cycle; a branch re-asserts it
    // only for the state being entered, so the bus is clean whenever nothing is active.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            in_cnt_q       <= '0;
            out_cnt_q      <= '0;
            in_idx_q       <= '0;
            out_idx_q      <= '0;
            init_q         <= '0;
            go_q           <= '0;
            byte_q         <= '0;
            sample_q       <= '0;
            res_q          <= '0;
            timer_q        <= '0;
            status_q       <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            src_rd_en_q    <= 1'b0;
            src_addr_q     <= '0;
            dst_wr_en_q    <= 1'b0;
            dst_addr_q     <= '0;
            dst_data_q     <= '0;
            bus_addr_q     <= '0;
            bus_data_out_q <= '0;
            bus_write_en_q <= 1'b0;
            bus_read_en_q  <= 1'b0;
        end else begin
            bus_write_en_q <= 1'b0;
            bus_read_en_q  <= 1'b0;
            bus_addr_q     <= '0;
            bus_data_out_q <= '0;
            src_rd_en_q    <= 1'b0;
            dst_wr_en_q    <= 1'b0;
            done_q         <= 1'b0;
            unique case (state_q)
                S_IDLE: if (start) begin
                    in_cnt_q       <= in_count;
                    out_cnt_q      <= out_count;
                    init_q         <= cfg_init_word;
                    go_q           <= cfg_go_word;
                    in_idx_q       <= '0;
                    out_idx_q      <= '0;
                    byte_q         <= '0;
                    error_q        <= 1'b0;
                    busy_q         <= 1'b1;
                    bus_write_en_q <= 1'b1;
                    bus_addr_q     <= reg_addr(CONFIG_REG_OFFSET, 2'd0);
                    bus_data_out_q <= cfg_init_word[7:0];
                    state_q        <= S_CFG_INIT;
                end
                S_CFG_INIT: if (byte_q == 2'd0) begin
                    byte_q         <= 2'd1;
                    bus_write_en_q <= 1'b1;
                    bus_addr_q     <= reg_addr(CONFIG_REG_OFFSET, 2'd1);
                    bus_data_out_q <= init_q[15:8];
                end else begin
                    byte_q <= '0;
                    if (in_cnt_q == '0) begin
                        bus_write_en_q <= 1'b1;
                        bus_addr_q     <= reg_addr(CONFIG_REG_OFFSET, 2'd0);
                        bus_data_out_q <= go_q[7:0];
                        state_q        <= S_CFG_GO;
                    end else begin
                        src_rd_en_q <= 1'b1;
                        src_addr_q  <= in_idx_q;
                        state_q     <= S_FETCH;
                    end
                end
                S_FETCH: state_q <= S_FETCH_WAIT;
                S_FETCH_WAIT: begin
                    sample_q       <= src_data;
                    byte_q         <= '0;
                    bus_write_en_q <= 1'b1;
                    bus_addr_q     <= reg_addr(INPUT_REG_OFFSET, 2'd0);
                    bus_data_out_q <= src_data[7:0];
                    state_q        <= S_IN_WR;
                end
                S_IN_WR: if (byte_q != 2'd3) begin
                    byte_q         <= byte_nxt;
                    bus_write_en_q <= 1'b1;
                    bus_addr_q     <= reg_addr(INPUT_REG_OFFSET, byte_nxt);
                    bus_data_out_q <= sample_q[{byte_nxt, 3'b000} +: 8];
                end else begin
                    byte_q   <= '0;
                    in_idx_q <= in_idx_nxt[MEM_ADDR_WIDTH-1:0];
                    if (in_idx_nxt < {1'b0, in_cnt_q}) begin
                        src_rd_en_q <= 1'b1;
                        src_addr_q  <= in_idx_nxt[MEM_ADDR_WIDTH-1:0];
                        state_q     <= S_FETCH;
                    end else begin
                        bus_write_en_q <= 1'b1;
                        bus_addr_q     <= reg_addr(CONFIG_REG_OFFSET, 2'd0);
                        bus_data_out_q <= go_q[7:0];
                        state_q        <= S_CFG_GO;
                    end
                end
                S_CFG_GO: if (byte_q == 2'd0) begin
                    byte_q         <= 2'd1;
                    bus_write_en_q <= 1'b1;
                    bus_addr_q     <= reg_addr(CONFIG_REG_OFFSET, 2'd1);
                    bus_data_out_q <= go_q[15:8];
                end else begin
                    byte_q <= '0;
                    if (out_cnt_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        timer_q       <= '0;
                        bus_read_en_q <= 1'b1;
                        bus_addr_q    <= reg_addr(CONFIG_REG_OFFSET, STATUS_BYTE);
                        state_q       <= S_POLL;
                    end
                end
                S_POLL: if (bus.bus_data_ready) begin
                    status_q <= bus.bus_data_in[STATUS_POS];
                    timer_q  <= '0;
                    state_q  <= S_POLL_GAP;
                end else if (timer_q == TIMER_LAST) begin
                    timer_q <= '0;
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end else begin
                    timer_q       <= timer_q + TW'(1);
                    bus_read_en_q <= 1'b1;
                    bus_addr_q    <= reg_addr(CONFIG_REG_OFFSET, STATUS_BYTE);
                end
                S_POLL_GAP: begin
                    timer_q       <= '0;
                    byte_q        <= '0;
                    bus_read_en_q <= 1'b1;
                    if (status_q) begin
                        bus_addr_q <= reg_addr(OUTPUT_REG_OFFSET, 2'd0);
                        state_q    <= S_OUT_RD;
                    end else begin
                        bus_addr_q <= reg_addr(CONFIG_REG_OFFSET, STATUS_BYTE);
                        state_q    <= S_POLL;
                    end
                end
                // Bytes 0..2 shift in from the top; byte 3 completes the word directly.
                S_OUT_RD: if (bus.bus_data_ready) begin
                    timer_q <= '0;
                    res_q   <= {bus.bus_data_in, res_q[SAMPLE_WIDTH-9:8]};
                    if (byte_q == 2'd3) begin
                        byte_q      <= '0;
                        dst_wr_en_q <= 1'b1;
                        dst_addr_q  <= out_idx_q;
                        dst_data_q  <= {bus.bus_data_in, res_q};
                        state_q     <= S_STORE;
                    end else begin
                        byte_q        <= byte_nxt;
                        bus_read_en_q <= 1'b1;
                        bus_addr_q    <= reg_addr(OUTPUT_REG_OFFSET, byte_nxt);
                    end
                end else if (timer_q == TIMER_LAST) begin
                    timer_q <= '0;
                    error_q <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end else begin
                    timer_q       <= timer_q + TW'(1);
                    bus_read_en_q <= 1'b1;
                    bus_addr_q    <= reg_addr(OUTPUT_REG_OFFSET, byte_q);
                end
                S_STORE: begin
                    out_idx_q <= out_idx_nxt[MEM_ADDR_WIDTH-1:0];
                    if (out_idx_nxt < {1'b0, out_cnt_q}) begin
                        timer_q       <= '0;
                        bus_read_en_q <= 1'b1;
                        bus_addr_q    <= reg_addr(CONFIG_REG_OFFSET, STATUS_BYTE);
                        state_q       <= S_POLL;
                    end else begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign error            = error_q;
    assign src_rd_en        = src_rd_en_q;
    assign src_addr         = src_addr_q;
    assign dst_wr_en        = dst_wr_en_q;
    assign dst_addr         = dst_addr_q;
    assign dst_data         = dst_data_q;
    assign bus.bus_addr     = bus_addr_q;
    assign bus.bus_data_out = bus_data_out_q;
    assign bus.bus_write_en = bus_write_en_q;
    assign bus.bus_read_en  = bus_read_en_q;
endmodule

// File: tb/tb_wavelet_dma_streamer.sv
// Directed bench for wavelet_dma_streamer: accelerator and SRAM models plus scoreboards
// for bus writes and destination writes.
module tb_wavelet_dma_streamer;
    localparam logic [31:0] BASE = 32'h1A100000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] in_count = '0, out_count = '0;
    logic [15:0] cfg_init_word = '0, cfg_go_word = '0;
    logic        busy, done, error, src_rd_en, dst_wr_en;
    logic [11:0] src_addr, dst_addr;
    logic [31:0] src_data, dst_data;

    wavelet_dma_streamer_if #(.ADDR_BUS_WIDTH(32)) bus_if ();

    wavelet_dma_streamer #(
        .ADDR_BUS_WIDTH(32), .BASE_ADDRESS(BASE), .SAMPLE_WIDTH(32),
        .MEM_ADDR_WIDTH(12), .STATUS_BIT(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .in_count(in_count), .out_count(out_count),
        .cfg_init_word(cfg_init_word), .cfg_go_word(cfg_go_word),
        .busy(busy), .done(done), .error(error),
        .src_rd_en(src_rd_en), .src_addr(src_addr), .src_data(src_data),
        .dst_wr_en(dst_wr_en), .dst_addr(dst_addr), .dst_data(dst_data),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SRAM models: 1-cycle read latency on the source side
    logic [31:0] src_mem [0:4095];
    logic [31:0] dst_mem [0:4095];
    logic [31:0] src_q = '0;
    always @(posedge clk) begin
        if (src_rd_en) src_q <= src_mem[src_addr];
        if (dst_wr_en) dst_mem[dst_addr] <= dst_data;
    end
    assign src_data = src_q;

    // Accelerator model: ready withheld on the first cycle of every read
    logic [31:0] acc_q [$];
    bit          status_q [$];
    bit          ready_block = 1'b0;
    logic        prev_re = 1'b0;
    logic [31:0] acc_off, acc_cur;
    int          poll_hs = 0;

    always @(negedge clk) begin
        acc_off = bus_if.bus_addr - BASE;
        bus_if.bus_data_ready = bus_if.bus_read_en && prev_re && !ready_block;
        prev_re = bus_if.bus_read_en;
        bus_if.bus_data_in = 8'h00;
        if (bus_if.bus_read_en) begin
            if (acc_off == 32'd0) begin
                bus_if.bus_data_in = (status_q.size() == 0 || status_q[0]) ? 8'h04 : 8'h00;
            end else if (acc_off >= 32'd8 && acc_off <= 32'd11 && acc_q.size() != 0) begin
                acc_cur = acc_q[0];
                bus_if.bus_data_in = 8'(acc_cur >> (8 * (acc_off - 32'd8)));
            end
        end
    end

    always @(posedge clk) begin
        if (bus_if.bus_read_en && bus_if.bus_data_ready) begin
            if (acc_off == 32'd0) begin
                poll_hs++;
                if (status_q.size() != 0) void'(status_q.pop_front());
            end else if (acc_off == 32'd11) begin
                if (acc_q.size() != 0) void'(acc_q.pop_front());
            end
        end
    end

    // Monitors and scoreboards
    typedef struct { logic [31:0] addr; logic [7:0] data; } wr_t;
    wr_t         wr_exp [$];
    logic [43:0] dst_exp [$];
    wr_t         wr_e;
    logic [43:0] dst_e;
    bit          wr_check_en = 1'b1;
    bit          prev_cfg_rd = 1'b0;
    int          done_cnt = 0, dst_seen = 0, poll_cycles = 0, out_cycles = 0, poll_gaps = 0;

    always @(negedge clk) begin
        if (rst) begin
            chk("strobe_excl", 64'(bus_if.bus_write_en && bus_if.bus_read_en), 64'd0);
            if (!bus_if.bus_write_en && !bus_if.bus_read_en)
                chk("idle_bus", {bus_if.bus_addr, bus_if.bus_data_out}, 64'd0);
            if (bus_if.bus_write_en && wr_check_en) begin
                chk("wr_expected", 64'(wr_exp.size() != 0), 64'd1);
                if (wr_exp.size() != 0) begin
                    wr_e = wr_exp.pop_front();
                    chk("wr_addr", bus_if.bus_addr, wr_e.addr);
                    chk("wr_data", bus_if.bus_data_out, wr_e.data);
                end
            end
            if (dst_wr_en) begin
                dst_seen++;
                chk("dst_expected", 64'(dst_exp.size() != 0), 64'd1);
                if (dst_exp.size() != 0) begin
                    dst_e = dst_exp.pop_front();
                    chk("dst_word", {dst_addr, dst_data}, dst_e);
                end
            end
            if (bus_if.bus_read_en && bus_if.bus_addr == BASE) poll_cycles++;
            if (bus_if.bus_read_en && bus_if.bus_addr >= BASE + 32'd8) out_cycles++;
            if (prev_cfg_rd && !bus_if.bus_read_en) poll_gaps++;
            prev_cfg_rd = bus_if.bus_read_en && bus_if.bus_addr == BASE;
            if (done) done_cnt++;
        end
    end

    task automatic push_wr(input logic [31:0] off, input logic [7:0] d);
        wr_t e;
        e.addr = BASE + off;
        e.data = d;
        wr_exp.push_back(e);
    endtask

    task automatic push_cfg(input logic [15:0] w);
        push_wr(32'd0, w[7:0]);
        push_wr(32'd1, w[15:8]);
    endtask

    task automatic push_sample(input logic [31:0] s);
        for (int unsigned b = 0; b < 4; b++) push_wr(32'd4 + b, 8'(s >> (8 * b)));
    endtask

    task automatic push_result(input logic [11:0] idx, input logic [31:0] r);
        acc_q.push_back(r);
        dst_exp.push_back({idx, r});
    endtask

    task automatic pulse_start(input logic [11:0] ic, input logic [11:0] oc,
                               input logic [15:0] iw, input logic [15:0] gw);
        @(negedge clk);
        in_count = ic; out_count = oc; cfg_init_word = iw; cfg_go_word = gw;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int bound);
        for (int i = 0; i < bound && busy; i++) @(negedge clk);
        chk(tag, 64'(busy), 64'd0);
        @(negedge clk);
    endtask

    int d0, p0, g0, o0, s0;
    bit found;

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk("rst_ctrl", {busy, done, error, src_rd_en, dst_wr_en}, 64'd0);
        chk("rst_mem_addr", {src_addr, dst_addr}, 64'd0);
        chk("rst_dst_data", dst_data, 64'd0);
        chk("rst_bus", {bus_if.bus_addr, bus_if.bus_data_out, bus_if.bus_write_en, bus_if.bus_read_en}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Two-sample run
        src_mem[0] = 32'hA1B2C3D4;
        src_mem[1] = 32'h01020304;
        push_cfg(16'h0002);
        push_sample(32'hA1B2C3D4);
        push_sample(32'h01020304);
        push_cfg(16'h0001);
        push_result(12'd0, 32'h5EED0042);
        d0 = done_cnt; p0 = poll_cycles; o0 = out_cycles;
        pulse_start(12'd2, 12'd1, 16'h0002, 16'h0001);
        chk("run1_busy", 64'(busy), 64'd1);
        wait_idle("run1_end", 300);
        chk("run1_done", 64'(done_cnt - d0), 64'd1);
        chk("run1_error", 64'(error), 64'd0);
        chk("run1_wr_left", 64'(wr_exp.size()), 64'd0);
        chk("run1_dst_left", 64'(dst_exp.size()), 64'd0);
        chk("run1_dst0", dst_mem[0], 64'h5EED0042);
        chk("run1_poll_cycles", 64'(poll_cycles - p0), 64'd2);
        chk("run1_out_cycles", 64'(out_cycles - o0), 64'd5);

        // Poll retry: status reads 0 three times before reading 1
        status_q.push_back(1'b0); status_q.push_back(1'b0); status_q.push_back(1'b0);
        src_mem[0] = 32'hDEADBEEF;
        push_cfg(16'h0004);
        push_sample(32'hDEADBEEF);
        push_cfg(16'h0008);
        push_result(12'd0, 32'h13579BDF);
        d0 = done_cnt; p0 = poll_hs; g0 = poll_gaps; o0 = out_cycles;
        pulse_start(12'd1, 12'd1, 16'h0004, 16'h0008);
        wait_idle("retry_end", 300);
        chk("retry_polls", 64'(poll_hs - p0), 64'd4);
        chk("retry_gaps", 64'(poll_gaps - g0), 64'd4);
        chk("retry_out_cycles", 64'(out_cycles - o0), 64'd5);
        chk("retry_done", 64'(done_cnt - d0), 64'd1);
        chk("retry_dst0", dst_mem[0], 64'h13579BDF);
        chk("retry_dst_left", 64'(dst_exp.size()), 64'd0);

        // start mid-run is ignored; latched counts stay 3 in / 2 out
        src_mem[0] = 32'h10203040; src_mem[1] = 32'h50607080; src_mem[2] = 32'h90A0B0C0;
        push_cfg(16'h0010);
        push_sample(32'h10203040); push_sample(32'h50607080); push_sample(32'h90A0B0C0);
        push_cfg(16'h0020);
        push_result(12'd0, 32'hAAAA5555);
        push_result(12'd1, 32'h0F1E2D3C);
        d0 = done_cnt;
        pulse_start(12'd3, 12'd2, 16'h0010, 16'h0020);
        repeat (8) @(negedge clk);
        pulse_start(12'd1, 12'd0, 16'hFFFF, 16'hFFFF);
        wait_idle("midstart_end", 400);
        chk("midstart_done", 64'(done_cnt - d0), 64'd1);
        chk("midstart_wr_left", 64'(wr_exp.size()), 64'd0);
        chk("midstart_dst_left", 64'(dst_exp.size()), 64'd0);
        chk("midstart_dst0", dst_mem[0], 64'hAAAA5555);
        chk("midstart_dst1", dst_mem[1], 64'h0F1E2D3C);
        repeat (5) @(negedge clk);
        chk("midstart_no_rerun", {31'd0, busy, 32'(done_cnt - d0)}, 64'd1);

        // Timeout: ready never arrives
        ready_block = 1'b1;
        push_cfg(16'h0002);
        push_cfg(16'h0001);
        d0 = done_cnt; p0 = poll_cycles; s0 = dst_seen;
        pulse_start(12'd0, 12'd1, 16'h0002, 16'h0001);
        for (int i = 0; i < 100 && !error; i++) @(negedge clk);
        chk("to_error", 64'(error), 64'd1);
        chk("to_busy", 64'(busy), 64'd0);
        chk("to_read_cycles", 64'(poll_cycles - p0), 64'd16);
        repeat (3) @(negedge clk);
        chk("to_sticky", {bus_if.bus_read_en, error}, 64'd1);
        chk("to_no_done", 64'(done_cnt - d0), 64'd0);
        chk("to_no_dst", 64'(dst_seen - s0), 64'd0);
        chk("to_wr_left", 64'(wr_exp.size()), 64'd0);
        ready_block = 1'b0;
        push_cfg(16'h0003);
        push_cfg(16'h0004);
        d0 = done_cnt;
        pulse_start(12'd0, 12'd0, 16'h0003, 16'h0004);
        chk("to_error_cleared", {busy, error}, 64'd2);
        wait_idle("to_clear_end", 100);
        chk("to_clear_done", 64'(done_cnt - d0), 64'd1);

        // Asynchronous reset during IN_WR byte 2
        src_mem[0] = 32'h11223344; src_mem[1] = 32'h55667788;
        wr_check_en = 1'b0;
        push_result(12'd0, 32'h77777777);
        pulse_start(12'd2, 12'd1, 16'h0002, 16'h0001);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (bus_if.bus_write_en && bus_if.bus_addr == BASE + 32'd6) found = 1'b1;
            else @(negedge clk);
        end
        chk("rstmid_reached_byte2", 64'(found), 64'd1);
        rst = 1'b0;
        #1;
        chk("rstmid_strobes", {bus_if.bus_write_en, bus_if.bus_read_en, src_rd_en, dst_wr_en, busy, done}, 64'd0);
        chk("rstmid_bus", {bus_if.bus_addr, bus_if.bus_data_out}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        wr_exp.delete(); acc_q.delete(); dst_exp.delete(); status_q.delete();
        wr_check_en = 1'b1;
        @(negedge clk);
        src_mem[0] = 32'hCAFEBABE;
        push_cfg(16'h0102);
        push_sample(32'hCAFEBABE);
        push_cfg(16'h0304);
        push_result(12'd0, 32'h24681357);
        d0 = done_cnt;
        pulse_start(12'd1, 12'd1, 16'h0102, 16'h0304);
        wait_idle("after_rst_end", 300);
        chk("after_rst_done", 64'(done_cnt - d0), 64'd1);
        chk("after_rst_dst0", dst_mem[0], 64'h24681357);
        chk("after_rst_wr_left", 64'(wr_exp.size()), 64'd0);
        chk("after_rst_error", 64'(error), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
